// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the icache, dcache and RAM signals of the memory arbiter. The
// arbiter connects through the slave modport. The master modport is the view
// from the caches and the RAM that surround it.
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    // icache side
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    // dcache side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    // RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload,
               ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload,
               ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the icache (read only) and the dcache (read/write) onto one
// single-port RAM. The module answers the cache request/wait protocol. A
// fairness counter limits how many dcache grants in a row can pass an
// icache read that is waiting.
// The optional macro MEM_TIMEOUT_EN adds a watchdog. After TIMEOUT service
// cycles with no ACCESS or ERROR it forces the transaction to complete.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_MAX = 4
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 64
`endif
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam int             SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);

    state_t          r_state;
    state_t          w_next_state;
    logic [SW-1:0]   r_starve_ct;
    logic            r_ram_err;

    logic            w_dreq;
    logic            w_done;
    logic            w_err;
    logic            w_tmo;
    logic            w_set_err;
    logic            w_st_inc;
    logic            w_st_clr;
    logic            w_enter;

    assign w_dreq = bus.dREN | bus.dWEN;
    assign w_done = (bus.ramstate == RAM_ACCESS) | (bus.ramstate == RAM_ERROR);
    assign w_err  = (bus.ramstate == RAM_ERROR);

    // Both caches see the RAM data directly. It is valid only while their wait is low.
    assign bus.iload   = bus.ramload;
    assign bus.dload   = bus.ramload;
    assign bus.ram_err = r_ram_err;

`ifdef MEM_TIMEOUT_EN
    localparam logic [6:0] TO_LIM = 7'(TIMEOUT - 1);
    logic [6:0] r_to_cnt;

    // The watchdog fires in the TIMEOUT-th service cycle. The counter is zero in the first service cycle.
    assign w_tmo = (r_to_cnt == TO_LIM);

    // Service-cycle counter: cleared on entry to a service state, counts while serving.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_to_cnt <= 7'd0;
        end else if (w_enter) begin
            r_to_cnt <= 7'd0;
        end else if (r_state != IDLE) begin
            r_to_cnt <= r_to_cnt + 7'd1;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // Arbitration, service control and completion handshake.
    always_comb begin
        w_next_state = r_state;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        w_set_err    = 1'b0;
        w_st_inc     = 1'b0;
        w_st_clr     = 1'b0;
        w_enter      = 1'b0;
        case (r_state)
            IDLE: begin
                // Serve the dcache first unless the icache has already been passed over STARVE_MAX times.
                if (w_dreq && (!bus.iREN || (r_starve_ct < STARVE_LIM))) begin
                    w_next_state = DSERV;
                    w_enter      = 1'b1;
                    if (bus.iREN) begin
                        w_st_inc = 1'b1;
                    end else begin
                        w_st_clr = 1'b1;
                    end
                end else if (bus.iREN) begin
                    w_next_state = ISERV;
                    w_enter      = 1'b1;
                    w_st_clr     = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            DSERV: begin
                bus.ramaddr = bus.daddr;
                // A write wins when the dcache raises both request lines.
                if (bus.dWEN) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramstore = bus.dstore;
                end else begin
                    bus.ramREN   = 1'b1;
                end
                if (!w_dreq) begin
                    // Request withdrawn: leave without a wait pulse.
                    w_next_state = IDLE;
                end else if (w_done || w_tmo) begin
                    bus.dwait    = 1'b0;
                    w_set_err    = w_err | w_tmo;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DSERV;
                end
            end
            ISERV: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = 1'b1;
                if (!bus.iREN) begin
                    w_next_state = IDLE;
                end else if (w_done || w_tmo) begin
                    bus.iwait    = 1'b0;
                    w_set_err    = w_err | w_tmo;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = ISERV;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fairness counter: counts dcache grants that pass a waiting icache, and saturates.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve_ct <= '0;
        end else if (w_st_inc) begin
            r_starve_ct <= (r_starve_ct == STARVE_LIM) ? r_starve_ct : r_starve_ct + SW'(1);
        end else if (w_st_clr) begin
            r_starve_ct <= '0;
        end else begin
            r_starve_ct <= r_starve_ct;
        end
    end

    // Sticky RAM error flag. Only reset clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ram_err <= 1'b0;
        end else if (w_set_err) begin
            r_ram_err <= 1'b1;
        end else begin
            r_ram_err <= r_ram_err;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter. Inputs change just after the falling
// edge. Outputs are sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_err;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to the middle of the next cycle. Callers then drive inputs and sample.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int first_low;
        logic exp_d;
        logic exp_i;
        n_cmp = 0;
        n_err = 0;

        nrst         = 1'b0;
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'd0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'd0;
        bus.dstore   = 32'd0;
        bus.ramload  = 32'd0;
        bus.ramstate = 2'd0;

        // ---------------- reset state ----------------
        #1;
        chk("rst_iwait",    {31'd0, bus.iwait},  32'd1);
        chk("rst_dwait",    {31'd0, bus.dwait},  32'd1);
        chk("rst_ramREN",   {31'd0, bus.ramREN}, 32'd0);
        chk("rst_ramWEN",   {31'd0, bus.ramWEN}, 32'd0);
        chk("rst_ramaddr",  bus.ramaddr,         32'd0);
        chk("rst_ramstore", bus.ramstore,        32'd0);
        chk("rst_ram_err",  {31'd0, bus.ram_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // ---------------- dcache read, 3 BUSY then ACCESS ----------------
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h0000_0100;
        bus.ramstate = 2'd1;
        bus.ramload  = 32'hDEAD_BEEF;
        #1;
        chk("rd_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("rd_idle_dwait",  {31'd0, bus.dwait},  32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("rd_busy_ramREN",  {31'd0, bus.ramREN}, 32'd1);
            chk("rd_busy_ramaddr", bus.ramaddr,         32'h0000_0100);
            chk("rd_busy_dwait",   {31'd0, bus.dwait},  32'd1);
            chk("rd_busy_iwait",   {31'd0, bus.iwait},  32'd1);
        end
        tick();
        bus.ramstate = 2'd2;
        #1;
        chk("rd_done_dwait",   {31'd0, bus.dwait},  32'd0);
        chk("rd_done_dload",   bus.dload,           32'hDEAD_BEEF);
        chk("rd_done_iwait",   {31'd0, bus.iwait},  32'd1);
        chk("rd_done_ramaddr", bus.ramaddr,         32'h0000_0100);
        tick();
        bus.dREN     = 1'b0;
        bus.ramstate = 2'd0;
        #1;
        chk("rd_turn_dwait",  {31'd0, bus.dwait},  32'd1);
        chk("rd_turn_ramREN", {31'd0, bus.ramREN}, 32'd0);

        // ---------------- dcache write, immediate ACCESS ----------------
        tick();
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.dstore   = 32'h1234_5678;
        bus.daddr    = 32'h0000_0040;
        bus.ramstate = 2'd2;
        #1;
        chk("wr_idle_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
        tick();
        #1;
        chk("wr_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
        chk("wr_ramREN",   {31'd0, bus.ramREN}, 32'd0);
        chk("wr_ramstore", bus.ramstore,        32'h1234_5678);
        chk("wr_ramaddr",  bus.ramaddr,         32'h0000_0040);
        chk("wr_dwait",    {31'd0, bus.dwait},  32'd0);
        tick();
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        #1;
        chk("wr_turn_ramWEN",   {31'd0, bus.ramWEN}, 32'd0);
        chk("wr_turn_ramREN",   {31'd0, bus.ramREN}, 32'd0);
        chk("wr_turn_ramaddr",  bus.ramaddr,         32'd0);
        chk("wr_turn_ramstore", bus.ramstore,        32'd0);
        chk("wr_turn_dwait",    {31'd0, bus.dwait},  32'd1);

        // ---------------- fairness: D,D,D,D,I,D,D,D,D,I ----------------
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0200;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h0000_0300;
        bus.ramstate = 2'd2;
        for (int k = 1; k <= 20; k++) begin
            tick();
            #1;
            if ((k % 2) == 1) begin
                exp_i = (((k + 1) / 2) % 5 == 0) ? 1'b0 : 1'b1;
                exp_d = ~exp_i;
            end else begin
                exp_i = 1'b1;
                exp_d = 1'b1;
            end
            chk($sformatf("fair_dwait_%0d", k), {31'd0, bus.dwait}, {31'd0, exp_d});
            chk($sformatf("fair_iwait_%0d", k), {31'd0, bus.iwait}, {31'd0, exp_i});
        end
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;

        // ---------------- ERROR sets the sticky flag ----------------
        tick();
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h0000_0080;
        bus.ramstate = 2'd3;
        tick();
        #1;
        chk("err_dwait", {31'd0, bus.dwait}, 32'd0);
        tick();
        bus.dREN     = 1'b0;
        bus.ramstate = 2'd2;
        #1;
        chk("err_flag",      {31'd0, bus.ram_err}, 32'd1);
        chk("err_turn_dwait", {31'd0, bus.dwait},  32'd1);
        bus.dREN = 1'b1;
        tick();
        #1;
        chk("err_ok_dwait", {31'd0, bus.dwait}, 32'd0);
        tick();
        bus.dREN = 1'b0;
        #1;
        chk("err_sticky", {31'd0, bus.ram_err}, 32'd1);

        // ---------------- asynchronous reset while in ISERV ----------------
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0500;
        bus.ramstate = 2'd1;
        bus.ramload  = 32'hCAFE_F00D;
        tick();
        #1;
        chk("irst_pre_ramREN",  {31'd0, bus.ramREN}, 32'd1);
        chk("irst_pre_ramaddr", bus.ramaddr,         32'h0000_0500);
        nrst = 1'b0;
        #1;
        chk("irst_ramREN",  {31'd0, bus.ramREN},  32'd0);
        chk("irst_iwait",   {31'd0, bus.iwait},   32'd1);
        chk("irst_ram_err", {31'd0, bus.ram_err}, 32'd0);
        chk("irst_ramaddr", bus.ramaddr,          32'd0);
        nrst = 1'b1;
        #1;
        chk("irst_rel_ramREN", {31'd0, bus.ramREN}, 32'd0);
        tick();
        #1;
        chk("irst_reg_ramREN", {31'd0, bus.ramREN}, 32'd1);
        bus.ramstate = 2'd2;
        #1;
        chk("irst_done_iwait", {31'd0, bus.iwait}, 32'd0);
        chk("irst_done_iload", bus.iload,          32'hCAFE_F00D);
        tick();
        bus.iREN     = 1'b0;
        bus.ramstate = 2'd1;

        // ---------------- stuck BUSY: timeout or indefinite wait ----------------
        tick();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h0000_0600;
        first_low = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            #1;
            if ((first_low == 0) && (bus.dwait == 1'b0)) begin
                first_low = k;
            end
        end
`ifdef MEM_TIMEOUT_EN
        chk("tmo_first_low", first_low,                 32'd64);
        chk("tmo_ram_err",   {31'd0, bus.ram_err},      32'd1);
`else
        chk("tmo_first_low", first_low,                 32'd0);
        chk("tmo_ram_err",   {31'd0, bus.ram_err},      32'd0);
`endif
        // Withdraw the request: no wait pulse, back to IDLE.
        bus.dREN = 1'b0;
        #1;
        chk("wd_dwait", {31'd0, bus.dwait}, 32'd1);
        tick();
        #1;
        chk("wd_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("wd_idle_dwait",  {31'd0, bus.dwait},  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
